legv8_multicycle_ctrl: RTL

Main control FSM for the multicycle LEGv8 core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write enables. It also drives the 2-bit ALU-op code consumed by the ALU control decoder. It sits beside the datapath and takes the IR opcode field, the ALU zero flag and a memory ready handshake.

---
 rtl/legv8_pkg.sv | 58 +++++
 rtl/legv8_opclass.sv | 36 +++
 rtl/legv8_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// ---------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the multicycle LEGv8 main control FSM:
//   - FSM state encodings (state_e)
//   - full 11-bit opcodes and the CBZ / B prefix patterns
//   - alu_op codes consumed by the ALU control decoder
//   - alu_src_b select codes
//   - opclass_t, the decoded opcode class bundle
// ---------------------------------------------------------------------------
package legv8_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_LOAD_WB   = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_TRAP      = 4'd15
  } state_e;

  // Full-width opcodes (IR[31:21])
  localparam logic [10:0] OPC_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OPC_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OPC_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OPC_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;

  // CBZ is identified by opcode[10:3], B by opcode[10:5]
  localparam logic [7:0] CBZ_PREFIX = 8'b1011_0100;
  localparam logic [5:0] B_PREFIX   = 6'b00_0101;

  // ALU operation codes
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_PASSB = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  // ALU B-operand selects
  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic rtype;
    logic load;
    logic store;
    logic cbz;
    logic b;
    logic illegal;
  } opclass_t;

endpackage

// File: rtl/legv8_opclass.sv
// ---------------------------------------------------------------------------
// legv8_opclass
// Purely combinational opcode classifier. Exactly one field of o_class is
// set for any input; anything not recognised is flagged illegal.
// Ports:
//   i_opcode [10:0]  IR[31:21]
//   o_class          {rtype, load, store, cbz, b, illegal}
// ---------------------------------------------------------------------------
module legv8_opclass
  import legv8_pkg::*;
(
  input  logic [10:0] i_opcode,
  output opclass_t    o_class
);

  logic w_rtype;
  logic w_load;
  logic w_store;
  logic w_cbz;
  logic w_b;

  assign w_rtype = (i_opcode == OPC_ADD) || (i_opcode == OPC_SUB) ||
                   (i_opcode == OPC_AND) || (i_opcode == OPC_ORR);
  assign w_load  = (i_opcode == OPC_LDUR);
  assign w_store = (i_opcode == OPC_STUR);
  assign w_cbz   = (i_opcode[10:3] == CBZ_PREFIX);
  assign w_b     = (i_opcode[10:5] == B_PREFIX);

  assign o_class.rtype   = w_rtype;
  assign o_class.load    = w_load;
  assign o_class.store   = w_store;
  assign o_class.cbz     = w_cbz;
  assign o_class.b       = w_b;
  assign o_class.illegal = ~(w_rtype | w_load | w_store | w_cbz | w_b);

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// legv8_multicycle_ctrl
// Main control FSM of the multicycle LEGv8 core. Steps one instruction at a
// time through FETCH / DECODE / EXECUTE / MEM / WB and drives the datapath
// mux selects, write enables and the 2-bit ALU-op code.
//
// Memory handshake: a memory access (FETCH, MEM_READ, MEM_WRITE) holds its
// request high and the FSM stays in that state until mem_ready=1, which marks
// the cycle the access completes; the state advances on that cycle's edge.
//
// Parameters:
//   PERF_W        width of the performance counters
//   ILLEGAL_HALT  1 = illegal opcode parks the FSM in TRAP, 0 = skip it
// Optional build macro:
//   LEGV8_MC_PERF_EN  adds cycle_cnt / instr_cnt outputs
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   opcode[10:0]          IR[31:21], valid from DECODE onward
//   zero                  ALU zero flag (consumed by the datapath PC logic)
//   mem_ready             memory completes the current access this cycle
//   pc_write .. alu_op    datapath controls (all 0 while reset=1)
//   illegal               one-cycle pulse in DECODE on an undecodable opcode
//   state_o[3:0]          current state for debug
//   cycle_cnt, instr_cnt  performance counters (LEGV8_MC_PERF_EN only)
// ---------------------------------------------------------------------------
module legv8_multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int PERF_W       = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              pc_source,
  output logic              ir_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              i_or_d,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              reg2loc,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic              illegal,
  output logic [3:0]        state_o
`ifdef LEGV8_MC_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instr_cnt
`endif
);

  if (PERF_W < 1) begin : g_perf_w_check
    $error("PERF_W must be at least 1");
  end

  state_e   r_state;
  opclass_t w_class;

  // The zero flag qualifies pc_write_cond inside the datapath; the FSM only
  // has to raise pc_write_cond in BRANCH, so zero is not needed here.
  logic w_unused_zero;
  assign w_unused_zero = zero;

  legv8_opclass u_opclass (
    .i_opcode (opcode),
    .o_class  (w_class)
  );

  // -------------------------------------------------------------------------
  // State register and next-state logic
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:     if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_class.rtype)                     r_state <= S_EXECUTE;
          else if (w_class.load || w_class.store) r_state <= S_MEM_ADDR;
          else if (w_class.cbz)                   r_state <= S_BRANCH;
          else if (w_class.b)                     r_state <= S_JUMP;
          else                                    r_state <= ILLEGAL_HALT ? S_TRAP : S_FETCH;
        end
        S_MEM_ADDR:  r_state <= w_class.store ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) r_state <= S_LOAD_WB;
        S_LOAD_WB:   r_state <= S_FETCH;
        S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXECUTE:   r_state <= S_R_WB;
        S_R_WB:      r_state <= S_FETCH;
        S_BRANCH:    r_state <= S_FETCH;
        S_JUMP:      r_state <= S_FETCH;
        S_TRAP:      r_state <= S_TRAP;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode. Moore outputs from r_state, plus the FETCH Mealy terms
  // (ir_write / pc_write follow mem_ready) and the DECODE illegal pulse.
  // Everything is held at 0 during reset so an aborted instruction can never
  // write anything on the reset cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg2loc       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REG;
    alu_op        = ALU_OP_ADD;
    illegal       = 1'b0;
    state_o       = 4'd0;
    if (!reset) begin
      state_o = r_state;
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALUB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          // Branch target PC + (imm<<2) is parked in ALUOut for BRANCH/JUMP
          alu_src_b = ALUB_IMM_SH2;
          reg2loc   = w_class.store | w_class.cbz;
          illegal   = w_class.illegal;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
          reg2loc   = w_class.store;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_LOAD_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          reg2loc   = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_RTYPE;
        end
        S_R_WB: begin
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_OP_PASSB;
          reg2loc       = 1'b1;
          pc_write_cond = 1'b1;
          pc_source     = 1'b1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LEGV8_MC_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
  logic [PERF_W-1:0] r_cycle_cnt;
  logic [PERF_W-1:0] r_instr_cnt;
  logic              w_complete;

  // An instruction retires on the edge that takes the FSM back into FETCH
  always_comb begin
    w_complete = 1'b0;
    case (r_state)
      S_LOAD_WB, S_R_WB, S_BRANCH, S_JUMP: w_complete = 1'b1;
      S_MEM_WRITE: w_complete = mem_ready;
      S_DECODE:    w_complete = w_class.illegal & ~ILLEGAL_HALT;
      default:     w_complete = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (r_state != S_TRAP) r_cycle_cnt <= r_cycle_cnt + PERF_W'(1);
      if (w_complete)        r_instr_cnt <= r_instr_cnt + PERF_W'(1);
    end
  end

  assign cycle_cnt = reset ? '0 : r_cycle_cnt;
  assign instr_cnt = reset ? '0 : r_instr_cnt;
`endif

endmodule
